// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, error codes and
// the FSM state type.
package mem_access_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_INV  = 2'b11;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_SIZE  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_t;

   // A word must sit on lane 0 and a half on an even lane.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
      return ((sz == SZ_WORD) && (lane != 2'b00)) || ((sz == SZ_HALF) && lane[0]);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: load-side lane select with sign/zero extension,
// store-side merge of a byte or half into the word read from memory.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sext,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rword[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_HALF: load_val = {{16{sext & half_sel[15]}}, half_sel};
         SZ_BYTE: load_val = {{24{sext & byte_sel[7]}}, byte_sel};
         default: load_val = rword;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LN = 2'(gi);
         logic       hit;
         logic [7:0] src;

         // Non-target lanes keep the byte that was read back.
         always_comb begin
            hit = 1'b1;
            src = wdata[8*gi +: 8];
            if (size == SZ_BYTE) begin
               hit = (lane == LN);
               src = wdata[7:0];
            end else if (size == SZ_HALF) begin
               hit = (lane[1] == LN[1]);
               src = LN[0] ? wdata[15:8] : wdata[7:0];
            end
         end

         assign store_word[8*gi +: 8] = hit ? src : rword[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/mem_access_seq.sv
// Multi-cycle load/store sequencer: one request in, one done pulse out, with
// configurable read latency, read-modify-write for sub-word stores and error checks.
module mem_access_seq
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int MEM_LAT     = 1,
   parameter bit ALIGN_CHECK = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t            state_reg, state_next;
   logic [3:0]        wait_cnt_reg;
   logic              st_store_reg, st_sext_reg;
   logic [1:0]        st_size_reg, st_lane_reg;
   logic [31:0]       st_wdata_reg;
   logic [31:0]       rdata_reg, mem_wdata_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic              err_reg;
   logic [1:0]        err_code_reg;

   logic              accept, req_bad_size, req_misalign, req_bad, read_last;
   logic [31:0]       load_val, store_word;

   assign accept       = start && (state_reg == ST_IDLE);
   assign req_bad_size = (size == SZ_INV);
   assign req_misalign = ALIGN_CHECK && misaligned(size, addr[1:0]);
   assign req_bad      = req_bad_size || req_misalign;
   assign read_last    = (state_reg == ST_READ) && (wait_cnt_reg == LAT_LAST);

   mem_lane_align u_align (
      .size       (st_size_reg),
      .lane       (st_lane_reg),
      .sext       (st_sext_reg),
      .rword      (mem_rdata),
      .wdata      (st_wdata_reg),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (req_bad)                                state_next = ST_DONE;
               else if (is_store && (size == SZ_WORD))     state_next = ST_WRITE;
               else                                        state_next = ST_READ;
            end
         end
         ST_READ: begin
            if (wait_cnt_reg == LAT_LAST) state_next = st_store_reg ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: state_next = ST_DONE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_reg != ST_IDLE);
      done   = (state_reg == ST_DONE);
      mem_wr = (state_reg == ST_WRITE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_reg  <= 4'd0;
         st_store_reg  <= 1'b0;
         st_sext_reg   <= 1'b0;
         st_size_reg   <= SZ_WORD;
         st_lane_reg   <= 2'b00;
         st_wdata_reg  <= 32'd0;
         rdata_reg     <= 32'd0;
         mem_wdata_reg <= 32'd0;
         mem_addr_reg  <= '0;
         err_reg       <= 1'b0;
         err_code_reg  <= ERR_NONE;
      end else begin
         if (accept) begin
            st_store_reg <= is_store;
            st_sext_reg  <= sext;
            st_size_reg  <= size;
            st_lane_reg  <= addr[1:0];
            st_wdata_reg <= wdata;
            mem_addr_reg <= {addr[ADDR_W-1:2], 2'b00};
            err_reg      <= req_bad;
            err_code_reg <= req_bad_size ? ERR_SIZE : (req_misalign ? ERR_ALIGN : ERR_NONE);
            if (!req_bad && is_store && (size == SZ_WORD)) mem_wdata_reg <= wdata;
         end
         if (state_reg == ST_READ) wait_cnt_reg <= read_last ? 4'd0 : wait_cnt_reg + 4'd1;
         // End of the read window: loads capture the result, sub-word stores the merged word.
         if (read_last) begin
            if (st_store_reg) mem_wdata_reg <= store_word;
            else              rdata_reg     <= load_val;
         end
      end
   end

   assign rdata     = rdata_reg;
   assign err       = err_reg;
   assign err_code  = err_code_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: transaction-level reference model with per-cycle compare,
// directed cases from the test plan, then randomized traffic with sporadic resets.
module tb_mem_access_seq;

   localparam int LAT_A = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start_a, start_b, is_store, sext;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic        busy_a, done_a, err_a, mem_wr_a;
   logic [1:0]  err_code_a;
   logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic        busy_b, done_b, err_b, mem_wr_b;
   logic [1:0]  err_code_b;
   logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   bit   [31:0] mem [64];
   bit   [31:0] rd1_a;
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [31:0] poke_val;
   int          done_cnt_a = 0;
   int          wr_cnt_a = 0;
   logic [31:0] last_waddr_a = 0, last_wdata_a = 0;

   int vec = 0;
   int miscmp = 0;
   int c = 0;

   mem_access_seq #(.ADDR_W(32), .MEM_LAT(LAT_A), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start_a), .is_store(is_store), .size(size),
      .sext(sext), .addr(addr), .wdata(wdata), .busy(busy_a), .done(done_a),
      .rdata(rdata_a), .err(err_a), .err_code(err_code_a), .mem_addr(mem_addr_a),
      .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
   );

   mem_access_seq #(.ADDR_W(32), .MEM_LAT(1), .ALIGN_CHECK(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .is_store(is_store), .size(size),
      .sext(sext), .addr(addr), .wdata(wdata), .busy(busy_b), .done(done_b),
      .rdata(rdata_b), .err(err_b), .err_code(err_code_b), .mem_addr(mem_addr_b),
      .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   // Memory environment: instance a sees a 2-cycle read pipe, instance b a 1-cycle one.
   always @(posedge clk) begin
      rd1_a <= mem[mem_addr_a[7:2]];
      if (poke_en)       mem[poke_idx] <= poke_val;
      else if (mem_wr_a) mem[mem_addr_a[7:2]] <= mem_wdata_a;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (mem_wr_a) begin
         wr_cnt_a     <= wr_cnt_a + 1;
         last_waddr_a <= mem_addr_a;
         last_wdata_a <= mem_wdata_a;
      end
   end
   assign mem_rdata_a = rd1_a;
   assign mem_rdata_b = mem[mem_addr_b[7:2]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", nm, c, act, exp);
      end
   endtask

   function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] ln, input logic sx);
      logic [31:0] v;
      if (sz == 2'b01) begin
         v = (w >> (16 * ln[1])) & 32'h0000FFFF;
         if (sx && v[15]) v = v | 32'hFFFF0000;
      end else if (sz == 2'b10) begin
         v = (w >> (8 * ln)) & 32'h000000FF;
         if (sx && v[7]) v = v | 32'hFFFFFF00;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic [31:0] wd);
      int          sh;
      logic [31:0] m;
      if (sz == 2'b01) begin
         sh = 16 * ln[1];
         m  = 32'h0000FFFF << sh;
      end else begin
         sh = 8 * ln;
         m  = 32'h000000FF << sh;
      end
      return (old & ~m) | ((wd << sh) & m);
   endfunction

   // Reference model and per-cycle compare for instance a.
   bit [31:0]   sm [64];
   bit          armed = 0, pending = 0, busy_m, ld_ok, has_wr, exp_e;
   int          done_t, wr_t, txn = 0;
   logic [1:0]  exp_code, t_sz;
   logic [31:0] exp_rd = 0, new_rd, exp_maddr, exp_wd, t_addr;
   logic        t_st;

   initial begin
      forever begin
         @(negedge clk);
         if (poke_en) sm[poke_idx] = poke_val;
         busy_m = pending;
         if (armed) begin
            chk("busy", {31'd0, busy_a}, {31'd0, busy_m});
            chk("done", {31'd0, done_a}, {31'd0, busy_m && (c == done_t)});
            chk("mem_wr", {31'd0, mem_wr_a}, {31'd0, busy_m && has_wr && (c == wr_t)});
            if (busy_m && !exp_e) chk("mem_addr", mem_addr_a, exp_maddr);
            if (busy_m && has_wr && (c == wr_t)) begin
               chk("mem_wdata", mem_wdata_a, exp_wd);
               sm[exp_maddr[7:2]] = exp_wd;
            end
            if (busy_m && (c == done_t)) begin
               chk("err", {31'd0, err_a}, {31'd0, exp_e});
               chk("err_code", {30'd0, err_code_a}, {30'd0, exp_code});
               if (ld_ok) exp_rd = new_rd;
               chk("rdata", rdata_a, exp_rd);
               txn++;
               $display("txn %0d: store=%0d size=%0d addr=%h err=%0d code=%0d rdata=%h",
                        txn, t_st, t_sz, t_addr, err_a, err_code_a, rdata_a);
               pending = 0;
            end else if (!busy_m) begin
               chk("rdata_hold", rdata_a, exp_rd);
            end
         end
         if (reset) begin
            armed   = 1;
            pending = 0;
            exp_rd  = 0;
         end else if (armed && start_a && !busy_m) begin
            pending   = 1;
            t_st      = is_store;
            t_sz      = size;
            t_addr    = addr;
            exp_maddr = {addr[31:2], 2'b00};
            has_wr    = 0;
            ld_ok     = 0;
            exp_e     = 0;
            exp_code  = 2'b00;
            if (size == 2'b11) begin
               exp_e = 1; exp_code = 2'b10; done_t = c + 1;
            end else if ((size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0])) begin
               exp_e = 1; exp_code = 2'b01; done_t = c + 1;
            end else if (!is_store) begin
               ld_ok  = 1;
               new_rd = ld_ext(sm[addr[7:2]], size, addr[1:0], sext);
               done_t = c + LAT_A + 1;
            end else if (size == 2'b00) begin
               has_wr = 1; wr_t = c + 1; exp_wd = wdata; done_t = c + 2;
            end else begin
               has_wr = 1;
               wr_t   = c + LAT_A + 1;
               exp_wd = st_merge(sm[addr[7:2]], size, addr[1:0], wdata);
               done_t = c + LAT_A + 2;
            end
         end
         c++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic poke(input int idx, input logic [31:0] val);
      poke_en = 1; poke_idx = 6'(idx); poke_val = val;
      step();
      poke_en = 0;
   endtask

   task automatic req_a(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] ad, input logic [31:0] wd, output int lat);
      is_store = st; size = sz; sext = sx; addr = ad; wdata = wd; start_a = 1;
      step();
      start_a = 0;
      lat = 1;
      while (!done_a && lat < 40) begin
         step();
         lat++;
      end
      chk("a_done_seen", {31'd0, done_a}, 32'd1);
   endtask

   task automatic req_b(input logic [1:0] sz, input logic sx, input logic [31:0] ad, output int lat);
      is_store = 0; size = sz; sext = sx; addr = ad; wdata = 0; start_b = 1;
      step();
      start_b = 0;
      lat = 1;
      while (!done_b && lat < 40) begin
         step();
         lat++;
      end
      chk("b_done_seen", {31'd0, done_b}, 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},     {31'd0, busy_a}, 32'd0);
      chk({tag, "_done"},     {31'd0, done_a}, 32'd0);
      chk({tag, "_err"},      {31'd0, err_a}, 32'd0);
      chk({tag, "_err_code"}, {30'd0, err_code_a}, 32'd0);
      chk({tag, "_rdata"},    rdata_a, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr_a, 32'd0);
      chk({tag, "_mem_wr"},   {31'd0, mem_wr_a}, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata_a, 32'd0);
   endtask

   initial begin
      int lat, w0, d0;
      reset = 1; start_a = 0; start_b = 0; is_store = 0; size = 0; sext = 0;
      addr = 0; wdata = 0; poke_en = 0; poke_idx = 0; poke_val = 0;
      repeat (2) step();
      for (int i = 0; i < 64; i++) poke(i, $urandom);
      reset = 0;
      chk_reset("post_reset");

      poke(4, 32'hDEADBEEF);
      req_a(0, 2'b00, 0, 32'h10, 0, lat);
      chk("lw_lat", lat, 3);
      chk("lw_rdata", rdata_a, 32'hDEADBEEF);
      chk("lw_err", {31'd0, err_a}, 32'd0);
      step();

      poke(4, 32'h80123456);
      req_a(0, 2'b10, 1, 32'h13, 0, lat);
      chk("lb_sext", rdata_a, 32'hFFFFFF80);
      step();
      req_a(0, 2'b10, 0, 32'h13, 0, lat);
      chk("lb_zext", rdata_a, 32'h00000080);
      step();

      poke(8, 32'h11223344);
      w0 = wr_cnt_a;
      req_a(1, 2'b10, 0, 32'h21, 32'h555555AB, lat);
      chk("sb_lat", lat, LAT_A + 2);
      chk("sb_wr_cnt", wr_cnt_a, w0 + 1);
      chk("sb_waddr", last_waddr_a, 32'h20);
      chk("sb_wdata", last_wdata_a, 32'h1122AB44);
      step();

      w0 = wr_cnt_a;
      req_a(0, 2'b01, 0, 32'h05, 0, lat);
      chk("lh_mis_lat", lat, 1);
      chk("lh_mis_err", {31'd0, err_a}, 32'd1);
      chk("lh_mis_code", {30'd0, err_code_a}, 32'd1);
      chk("lh_mis_nowr", wr_cnt_a, w0);
      step();

      req_a(1, 2'b11, 0, 32'h40, 32'h12345678, lat);
      chk("inv_lat", lat, 1);
      chk("inv_code", {30'd0, err_code_a}, 32'd2);
      chk("inv_nowr", wr_cnt_a, w0);
      step();

      d0 = done_cnt_a;
      is_store = 0; size = 2'b00; addr = 32'h10; start_a = 1;
      step();
      addr = 32'h20;
      step();
      start_a = 0;
      repeat (6) step();
      chk("busy_ignore", done_cnt_a - d0, 1);

      w0 = wr_cnt_a;
      is_store = 1; size = 2'b01; addr = 32'h22; wdata = 32'h0000BEEF; start_a = 1;
      step();
      start_a = 0; reset = 1;
      step();
      reset = 0;
      chk_reset("mid_reset");
      repeat (4) step();
      chk("mid_reset_nowr", wr_cnt_a, w0);
      chk("mid_reset_mem", mem[8], 32'h1122AB44);
      req_a(0, 2'b00, 0, 32'h10, 0, lat);
      chk("after_reset_lat", lat, 3);
      chk("after_reset_rdata", rdata_a, 32'h80123456);
      step();

      poke(1, 32'h1234F00D);
      req_b(2'b01, 1, 32'h05, lat);
      chk("b_lh_lat", lat, 2);
      chk("b_lh_err", {31'd0, err_b}, 32'd0);
      chk("b_lh_code", {30'd0, err_code_b}, 32'd0);
      chk("b_lh_rdata", rdata_b, 32'hFFFFF00D);
      chk("b_lh_maddr", mem_addr_b, 32'h4);
      step();
      req_b(2'b00, 0, 32'h07, lat);
      chk("b_lw_rdata", rdata_b, 32'h1234F00D);
      chk("b_lw_err", {31'd0, err_b}, 32'd0);
      chk("b_busy_wr", {30'd0, busy_b, mem_wr_b}, 32'd2);
      step();

      for (int i = 0; i < 800; i++) begin
         start_a  = ($urandom_range(0, 2) == 0);
         is_store = 1'($urandom_range(0, 1));
         size     = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         sext     = 1'($urandom_range(0, 1));
         addr     = {24'd0, 8'($urandom)};
         if ($urandom_range(0, 3) != 0) begin
            if (size == 2'b00)      addr[1:0] = 2'b00;
            else if (size == 2'b01) addr[0]   = 1'b0;
         end
         wdata = $urandom;
         reset = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 0; start_a = 0;
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Multi-cycle load/store sequencer for the multicycle MIPS datapath. It replaces the hard-wired LOAD_WAIT/STORE_WAIT states and set-load-size/set-store-size muxing in the control unit with one parametrised block. The control unit issues one request and waits for `done`. The block drives the byte-addressed synchronous memory, inserts a configurable number of wait cycles, and extracts and extends loaded bytes or halfwords. Sub-word stores use read-modify-write, and misaligned or invalid requests are flagged as exceptions without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width (≥ 3).
- `MEM_LAT`, 1: memory read latency in cycles (1..15).
- `ALIGN_CHECK`, 1: when 1, misaligned requests raise `err`; when 0, address bits below the access size are ignored.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset. One clock; reset is synchronous and active-high.
- `start` in 1: request strobe, accepted only when `busy`=0.
- `is_store` in 1: 1 = store, 0 = load.
- `size` in 2: 00 word, 01 half, 10 byte, 11 invalid.
- `sext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data; low bits are used for half and byte stores.
- `busy` out 1: block is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, valid while `done`=1 and held until the next accept.
- `err` out 1: valid with `done`; the request was rejected.
- `err_code` out 2: 01 misaligned, 10 invalid size; 00 otherwise.
- `mem_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wr` out 1: memory write enable.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid MEM_LAT cycles after `mem_addr` is presented with `mem_wr`=0.

## Operation
- States: IDLE, READ, WRITE, DONE.
- On accept, latch `is_store`, `size`, `sext`, `addr` and `wdata`. While busy, `start` is ignored; it is neither queued nor errored.
- Lane: `lane = addr[1:0]`, little-endian. Byte k occupies bits [8k+7:8k]; the half at `lane[1]` occupies bits [16·lane[1]+15 : 16·lane[1]].
- Validity check at accept:
  - `size`=11 → IDLE→DONE with `err`=1, `err_code`=10.
  - If ALIGN_CHECK=1: word with lane≠0, or half with lane[0]=1 → IDLE→DONE with `err`=1, `err_code`=01.
  - No memory access occurs on either error path.
- Load: IDLE→READ. The block stays in READ for MEM_LAT cycles, samples `mem_rdata` at the end of the last READ cycle, then moves to DONE. `rdata` is the selected lane, extended per `sext`.
- Word store: IDLE→WRITE with `mem_wr`=1 and `mem_wdata`=`wdata`, then →DONE.
- Half/byte store: IDLE→READ (MEM_LAT cycles), then →WRITE. In WRITE, `mem_wdata` is the read word with only the target lane replaced by `wdata[15:0]` or `wdata[7:0]`. Then →DONE.
- DONE: `done`=1 for exactly one cycle, then →IDLE.
- Stores leave `rdata` unchanged.
- `mem_wr`=1 only in WRITE.
- `mem_addr` is held constant from READ through WRITE.

## Timing
- Accept on cycle T, when `start`=1 and the state is IDLE.
- `done` cycle:
  - Load: T+MEM_LAT+1.
  - Word store: T+2.
  - Half/byte store: T+MEM_LAT+2.
  - Error: T+1.
- `busy`=1 from T+1 through the `done` cycle.
- A new request can be accepted at the first IDLE cycle after `done`, so back-to-back accept spacing is at least latency+1.
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_wr`=0; `err_code`=00; `rdata`, `mem_addr`, `mem_wdata`=0; wait counter 0.
- Reset asserted mid-operation: the next edge returns the block to IDLE with `mem_wr`=0. A write in progress on that same edge still commits to memory; no partial merge is retried.
- `start` and `reset` together: reset wins, and the request is dropped.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings: SZ_WORD, SZ_HALF, SZ_BYTE, SZ_INV;
  - err_code constants: ERR_NONE, ERR_ALIGN, ERR_SIZE;
  - the state encoding.
- Sub-module `mem_lane_align`, purely combinational:
  - load path: lane select plus sign/zero extension;
  - store path: byte/half merge into the read word.
- The FSM, wait counter (4 bits) and request latches are in the top level.

## Test plan
- MEM_LAT=2, load word at 0x10, memory word 0xDEADBEEF → `done` at T+3, `rdata`=0xDEADBEEF, `err`=0.
- Load byte at 0x13 with `sext`=1, memory word 0x80123456 → `rdata`=0xFFFFFF80. With `sext`=0 → `rdata`=0x00000080.
- Store byte 0xAB at 0x21, memory word 0x11223344 → one WRITE of 0x1122AB44 at `mem_addr` 0x20, `done` at T+MEM_LAT+2.
- Load half at 0x05 with ALIGN_CHECK=1 → `done`+`err` at T+1, `err_code`=01, `mem_wr` never asserted. With ALIGN_CHECK=0 → normal access of the half at lane 0 of word 0x04.
- `size`=11 → `err_code`=10 at T+1. A `start` pulsed while busy is ignored: exactly one `done` is produced.
- `reset` asserted in the first READ cycle of a half store → IDLE next cycle, no `mem_wr`, all outputs at reset values, and the next request completes normally.
